// File: rtl/wb_grf_pkg.sv
// Shared CPU constants for the writeback stage: writeback-source and load-type encodings.
// The controller drives these same encodings into the M/W pipeline register.
package wb_grf_pkg;

  typedef enum logic [1:0] {
    WSEL_ALU  = 2'd0,
    WSEL_MEM  = 2'd1,
    WSEL_LINK = 2'd2,
    WSEL_RSVD = 2'd3
  } wsel_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4
  } ld_op_e;

  localparam int unsigned NREGS = 32;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/wb_grf_if.sv
// W-stage bundle, D-stage read ports and commit trace of the writeback/GRF block.
// master = pipeline/bench side, slave = wb_grf.
interface wb_grf_if;
  logic        regwrite_w;
  logic [1:0]  wsel_w;
  logic [2:0]  ld_op_w;
  logic [31:0] pc_w;
  logic [31:0] instr_w;
  logic [31:0] ao_w;
  logic [31:0] dr_w;
  logic [4:0]  a3_w;
  logic [4:0]  rs_addr_d;
  logic [4:0]  rt_addr_d;
  logic [31:0] rs_data_d;
  logic [31:0] rt_data_d;
  logic [31:0] wb_data_w;
  logic        wb_en_w;
  logic [31:0] retire_cnt;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_reg;
  logic [31:0] trace_data;

  modport master (
    output regwrite_w, wsel_w, ld_op_w, pc_w, instr_w, ao_w, dr_w, a3_w,
           rs_addr_d, rt_addr_d,
    input  rs_data_d, rt_data_d, wb_data_w, wb_en_w, retire_cnt,
           trace_valid, trace_pc, trace_reg, trace_data
  );

  modport slave (
    input  regwrite_w, wsel_w, ld_op_w, pc_w, instr_w, ao_w, dr_w, a3_w,
           rs_addr_d, rt_addr_d,
    output rs_data_d, rt_data_d, wb_data_w, wb_en_w, retire_cnt,
           trace_valid, trace_pc, trace_reg, trace_data
  );
endinterface

// File: rtl/wb_load_ext.sv
// Load extension: picks the byte/half lane of the raw memory word and sign/zero extends it.
// Purely combinational; unknown load types behave as lw.
module wb_load_ext
  import wb_grf_pkg::*;
(
  input  logic [31:0] dr_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  ld_op_i,
  output logic [31:0] data_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = dr_i[7:0];
    case (lane_i)
      2'd0:    byteSel = dr_i[7:0];
      2'd1:    byteSel = dr_i[15:8];
      2'd2:    byteSel = dr_i[23:16];
      default: byteSel = dr_i[31:24];
    endcase
    // Halfword lane ignores the low address bit.
    halfSel = lane_i[1] ? dr_i[31:16] : dr_i[15:0];
  end

  always_comb begin
    data_o = dr_i;
    case (ld_op_i)
      LD_LB:   data_o = ext8(byteSel, 1'b1);
      LD_LBU:  data_o = ext8(byteSel, 1'b0);
      LD_LH:   data_o = ext16(halfSel, 1'b1);
      LD_LHU:  data_o = ext16(halfSel, 1'b0);
      default: data_o = dr_i;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// Writeback stage plus 32x32 general register file with same-cycle write bypass,
// retire counter and a one-cycle-delayed commit trace.
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter logic [31:0] LINK_OFFSET = 32'd8,
  parameter bit          TRACE_EN    = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  wb_grf_if.slave  bus
);

  logic [31:0] extData;
  logic [31:0] wbData;
  logic        wbEn;
  logic [31:0] rsData;
  logic [31:0] rtData;

  logic [31:0] grf_q [NREGS];
  logic [31:0] retireCnt_q, retireCnt_d;
  logic        traceValid_q;
  logic [31:0] tracePc_q;
  logic [4:0]  traceReg_q;
  logic [31:0] traceData_q;

  wb_load_ext u_load_ext (
    .dr_i    (bus.dr_w),
    .lane_i  (bus.ao_w[1:0]),
    .ld_op_i (bus.ld_op_w),
    .data_o  (extData)
  );

  always_comb begin
    wbData = '0;
    case (bus.wsel_w)
      WSEL_ALU:  wbData = bus.ao_w;
      WSEL_MEM:  wbData = extData;
      WSEL_LINK: wbData = bus.pc_w + LINK_OFFSET;
      default:   wbData = '0;
    endcase
  end

  assign wbEn = bus.regwrite_w && (bus.a3_w != 5'd0) && (bus.wsel_w != WSEL_RSVD);

  // The bypass lets D read a value being committed this very edge without a stall.
  always_comb begin
    rsData = grf_q[bus.rs_addr_d];
    if (bus.rs_addr_d == 5'd0) begin
      rsData = '0;
    end else if (wbEn && (bus.rs_addr_d == bus.a3_w)) begin
      rsData = wbData;
    end
  end

  always_comb begin
    rtData = grf_q[bus.rt_addr_d];
    if (bus.rt_addr_d == 5'd0) begin
      rtData = '0;
    end else if (wbEn && (bus.rt_addr_d == bus.a3_w)) begin
      rtData = wbData;
    end
  end

  assign retireCnt_d = retireCnt_q + {31'd0, (bus.instr_w != 32'd0)};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        grf_q[i] <= '0;
      end
    end else if (wbEn) begin
      grf_q[bus.a3_w] <= wbData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retireCnt_q <= '0;
    end else begin
      retireCnt_q <= retireCnt_d;
    end
  end

  // Trace payload holds between commits so the grader can see the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      traceValid_q <= 1'b0;
      tracePc_q    <= '0;
      traceReg_q   <= '0;
      traceData_q  <= '0;
    end else begin
      traceValid_q <= wbEn && TRACE_EN;
      if (wbEn && TRACE_EN) begin
        tracePc_q   <= bus.pc_w;
        traceReg_q  <= bus.a3_w;
        traceData_q <= wbData;
      end
    end
  end

  assign bus.rs_data_d   = rsData;
  assign bus.rt_data_d   = rtData;
  assign bus.wb_data_w   = wbData;
  assign bus.wb_en_w     = wbEn;
  assign bus.retire_cnt  = retireCnt_q;
  assign bus.trace_valid = traceValid_q;
  assign bus.trace_pc    = tracePc_q;
  assign bus.trace_reg   = traceReg_q;
  assign bus.trace_data  = traceData_q;

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: reference register/counter model plus a trace scoreboard
// filled when a commit is driven and drained when the registered trace appears.
module tb_wb_grf;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  wb_grf_if bus ();

  wb_grf #(
    .LINK_OFFSET (32'd8),
    .TRACE_EN    (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } trace_t;

  trace_t      sb [$];
  logic [31:0] modelGrf [32];
  logic [31:0] modelRetire;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelLoad(input logic [31:0] dr, input logic [1:0] lane,
                                            input logic [2:0] ld);
    logic [31:0] bsh;
    logic [31:0] hsh;
    logic [7:0]  b;
    logic [15:0] h;
    bsh = dr >> {lane, 3'b000};
    hsh = dr >> {lane[1], 4'b0000};
    b   = bsh[7:0];
    h   = hsh[15:0];
    case (ld)
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {24'd0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {16'd0, h};
      default: return dr;
    endcase
  endfunction

  function automatic logic [31:0] modelWb();
    case (bus.wsel_w)
      2'd0:    return bus.ao_w;
      2'd1:    return modelLoad(bus.dr_w, bus.ao_w[1:0], bus.ld_op_w);
      2'd2:    return bus.pc_w + 32'd8;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic commitNow();
    return bus.regwrite_w && (bus.a3_w != 5'd0) && (bus.wsel_w != 2'd3);
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (commitNow() && (addr == bus.a3_w)) return modelWb();
    return modelGrf[addr];
  endfunction

  task automatic applyStimulus(input logic rw, input logic [1:0] ws, input logic [2:0] ld,
                               input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] ao, input logic [31:0] dr,
                               input logic [4:0] a3, input logic [4:0] rs, input logic [4:0] rt);
    bus.regwrite_w = rw;
    bus.wsel_w     = ws;
    bus.ld_op_w    = ld;
    bus.pc_w       = pc;
    bus.instr_w    = instr;
    bus.ao_w       = ao;
    bus.dr_w       = dr;
    bus.a3_w       = a3;
    bus.rs_addr_d  = rs;
    bus.rt_addr_d  = rt;
  endtask

  task automatic checkReads(input string tag);
    checkOutput({tag, "_rs"}, bus.rs_data_d, modelRead(bus.rs_addr_d));
    checkOutput({tag, "_rt"}, bus.rt_data_d, modelRead(bus.rt_addr_d));
  endtask

  // Advance one edge from a negedge: update the model, then check trace and counter.
  task automatic stepClock();
    trace_t e;
    if (reset) begin
      for (int i = 0; i < 32; i++) modelGrf[i] = 32'd0;
      modelRetire = 32'd0;
    end else begin
      if (commitNow()) begin
        e.pc   = bus.pc_w;
        e.rd   = bus.a3_w;
        e.data = modelWb();
        sb.push_back(e);
        modelGrf[bus.a3_w] = e.data;
      end
      if (bus.instr_w != 32'd0) modelRetire = modelRetire + 32'd1;
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("trace_valid", {31'd0, bus.trace_valid}, 32'd1);
      checkOutput("trace_pc", bus.trace_pc, e.pc);
      checkOutput("trace_reg", {27'd0, bus.trace_reg}, {27'd0, e.rd});
      checkOutput("trace_data", bus.trace_data, e.data);
    end else begin
      checkOutput("trace_idle", {31'd0, bus.trace_valid}, 32'd0);
    end
    checkOutput("retire", bus.retire_cnt, modelRetire);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0]  ldOps   [4];
    logic [1:0]  lanes   [4];
    logic [31:0] ldExp   [4];
    logic        instrOn [8];
    logic [4:0]  dst;

    checks      = 0;
    failures    = 0;
    modelRetire = 32'd0;
    for (int i = 0; i < 32; i++) modelGrf[i] = 32'd0;

    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    stepClock();
    stepClock();
    reset = 1'b0;

    // Reset state
    applyStimulus(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
    #1;
    checkOutput("t1_rs", bus.rs_data_d, 32'd0);
    checkOutput("t1_rt", bus.rt_data_d, 32'd0);
    checkOutput("t1_retire", bus.retire_cnt, 32'd0);
    checkOutput("t1_trace_valid", {31'd0, bus.trace_valid}, 32'd0);
    stepClock();

    // ALU write with bypass, then array read
    applyStimulus(1'b1, 2'd0, 3'd0, 32'h0000_1000, 32'h0085_1020, 32'h1234_5678, 32'd0,
                  5'd8, 5'd8, 5'd0);
    #1;
    checkOutput("t2_bypass", bus.rs_data_d, 32'h1234_5678);
    checkOutput("t2_wb_en", {31'd0, bus.wb_en_w}, 32'd1);
    stepClock();
    checkOutput("t2_trace_reg", {27'd0, bus.trace_reg}, 32'd8);
    applyStimulus(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd8, 5'd0);
    #1;
    checkOutput("t2_array", bus.rs_data_d, 32'h1234_5678);
    stepClock();

    // Load extension
    ldOps[0] = 3'd1; lanes[0] = 2'd3; ldExp[0] = 32'hFFFF_FF80;
    ldOps[1] = 3'd2; lanes[1] = 2'd3; ldExp[1] = 32'h0000_0080;
    ldOps[2] = 3'd3; lanes[2] = 2'd2; ldExp[2] = 32'hFFFF_80FF;
    ldOps[3] = 3'd4; lanes[3] = 2'd0; ldExp[3] = 32'h0000_7F01;
    for (int k = 0; k < 4; k++) begin
      dst = 5'd9 + 5'(k);
      applyStimulus(1'b1, 2'd1, ldOps[k], 32'h0000_1100 + 32'(4 * k), 32'h8C00_0000 + 32'(k),
                    {30'h1000_0000, lanes[k]}, 32'h80FF_7F01, dst, dst, 5'd8);
      #1;
      checkOutput("t3_wb", bus.wb_data_w, ldExp[k]);
      checkReads("t3");
      stepClock();
    end

    // Write to $0 is dropped but still retires
    applyStimulus(1'b1, 2'd0, 3'd0, 32'h0000_1200, 32'h2000_0001, 32'hDEAD_BEEF, 32'd0,
                  5'd0, 5'd0, 5'd0);
    #1;
    checkOutput("t4_r0", bus.rs_data_d, 32'd0);
    checkOutput("t4_wb_en", {31'd0, bus.wb_en_w}, 32'd0);
    stepClock();

    // Link write, then reset beats a simultaneous write
    applyStimulus(1'b1, 2'd2, 3'd0, 32'h0000_3000, 32'h0C00_0400, 32'd0, 32'd0,
                  5'd31, 5'd31, 5'd0);
    #1;
    checkOutput("t5_link_wb", bus.wb_data_w, 32'h0000_3008);
    stepClock();
    applyStimulus(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd31, 5'd0);
    #1;
    checkOutput("t5_link_array", bus.rs_data_d, 32'h0000_3008);
    reset = 1'b1;
    applyStimulus(1'b1, 2'd0, 3'd0, 32'h0000_3004, 32'h0000_0055, 32'h0000_0055, 32'd0,
                  5'd31, 5'd31, 5'd31);
    stepClock();
    reset = 1'b0;
    applyStimulus(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd31, 5'd8);
    #1;
    checkOutput("t5_r31_cleared", bus.rs_data_d, 32'd0);
    checkOutput("t5_r8_cleared", bus.rt_data_d, 32'd0);
    checkOutput("t5_trace_valid", {31'd0, bus.trace_valid}, 32'd0);
    stepClock();

    // Instructions interleaved with bubbles, back-to-back same-register writes
    instrOn = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      if (instrOn[k]) begin
        dst = (k < 4) ? 5'd3 : 5'd4;
        applyStimulus(1'b1, 2'd0, 3'd0, 32'h0000_2000 + 32'(4 * k), 32'h0000_0020 + 32'(k),
                      32'hA000_0000 + 32'(k), 32'd0, dst, dst, dst);
      end else begin
        applyStimulus(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd4);
      end
      #1;
      checkReads("t6");
      stepClock();
    end
    checkOutput("t6_retire5", bus.retire_cnt, 32'd5);
    applyStimulus(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd4);
    #1;
    checkOutput("t6_last_wins", bus.rs_data_d, 32'hA000_0003);

    // Counter wrap from a preloaded all-ones value
    force dut.retireCnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retireCnt_q;
    modelRetire = 32'hFFFF_FFFF;
    #1;
    checkOutput("t6_preload", bus.retire_cnt, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 2'd0, 3'd0, 32'h0000_2100, 32'h0000_0001, 32'd0, 32'd0,
                  5'd0, 5'd0, 5'd0);
    stepClock();
    checkOutput("t6_wrap", bus.retire_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
